imem_prefetch_buffer: RTL and testbench

//  Parametrised successor to the fixed 4-word instruction fetcher. Streams a packet image out of the

---
 rtl/imem_pkg.sv | 28 ++
 rtl/imem_rd_pipe.sv | 61 ++++++
 rtl/imem_prefetch_buffer.sv | 219 +++++++++++++++++++++
 tb/tb_imem_prefetch_buffer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory prefetch buffer: FSM encoding,
// default word geometry and a constant-evaluable ceil(log2) helper.
package imem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } imem_state_t;

    localparam int DEFAULT_MEM_DW = 32;
    localparam int BYTES_PER_WORD = DEFAULT_MEM_DW / 8;

    // Number of bits needed to index 'value' distinct items (0 for value <= 1).
    function automatic int clog2(input int value);
        int result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Bytes carried by one SRAM word of the given width.
    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/imem_rd_pipe.sv
// Read-latency tracker: one stage per cycle of SRAM latency. Each stage holds
// a valid bit plus the byte count the returning word carries, so the top
// knows when data lands and how many of its bytes are meaningful.
module imem_rd_pipe
    import imem_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int TAG_W  = 3,
    parameter int PCNT_W = clog2(RD_LAT + 1)
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [TAG_W-1:0]  push_tag,
    output logic              land_valid,
    output logic [TAG_W-1:0]  land_tag,
    output logic [PCNT_W-1:0] pending_cnt
);

    logic             vld_reg [RD_LAT];
    logic [TAG_W-1:0] tag_reg [RD_LAT];

    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
            logic             vld_in;
            logic [TAG_W-1:0] tag_in;

            if (gi == 0) begin : g_head
                assign vld_in = push;
                assign tag_in = push_tag;
            end else begin : g_body
                assign vld_in = vld_reg[gi-1];
                assign tag_in = tag_reg[gi-1];
            end

            // Advance one stage per clock; reset drops every read in flight.
            always_ff @(posedge clk) begin
                if (reset) begin
                    vld_reg[gi] <= 1'b0;
                    tag_reg[gi] <= '0;
                end else begin
                    vld_reg[gi] <= vld_in;
                    tag_reg[gi] <= tag_in;
                end
            end
        end
    endgenerate

    assign land_valid = vld_reg[RD_LAT-1];
    assign land_tag   = tag_reg[RD_LAT-1];

    // Count reads between the SRAM access cycle and the data-return cycle.
    always_comb begin
        pending_cnt = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            pending_cnt = pending_cnt + PCNT_W'(vld_reg[i]);
        end
    end

endmodule

// File: rtl/imem_prefetch_buffer.sv
// Instruction prefetch window. Streams a byte-counted packet image from the
// instruction SRAM into a WIN_WORDS-deep MSB-first window, keeping the window
// topped up while the consumer retires words from the head.
module imem_prefetch_buffer
    import imem_pkg::*;
#(
    parameter int MEM_DW    = 32,
    parameter int ADDR_W    = 10,
    parameter int WIN_WORDS = 4,
    parameter int RD_LAT    = 1,
    parameter int CNT_W     = 17
)(
    input  logic                            clk,
    input  logic                            reset,
    output logic                            imem_ceb,
    output logic                            imem_web,
    output logic [ADDR_W-1:0]               imem_addr,
    input  logic [MEM_DW-1:0]               imem_rdata,
    input  logic                            start,
    input  logic [ADDR_W-1:0]               base_addr,
    input  logic [CNT_W-1:0]                expectedBytes,
    input  logic [clog2(WIN_WORDS+1)-1:0]   consume_words,
    output logic [WIN_WORDS*MEM_DW-1:0]     instruction_word,
    output logic [WIN_WORDS*MEM_DW/8-1:0]   instruction_valid_bytes,
    output logic                            busy,
    output logic                            done_reading_memory,
    output logic                            consume_err
);

    localparam int BPW    = bytes_per_word(MEM_DW);
    localparam int WIN_DW = WIN_WORDS * MEM_DW;
    localparam int VB_W   = WIN_WORDS * BPW;
    localparam int CW     = clog2(WIN_WORDS + 1);
    localparam int TAG_W  = clog2(BPW + 1);
    localparam int PCNT_W = clog2(RD_LAT + 1);

    imem_state_t state_reg, state_next;

    logic               ceb_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [ADDR_W-1:0]  next_addr_reg;
    logic [CNT_W-1:0]   issued_reg;
    logic [CNT_W-1:0]   expected_reg;
    logic [TAG_W-1:0]   issue_tag_reg;

    logic [WIN_DW-1:0]  window_reg, window_shift, window_next;
    logic [VB_W-1:0]    vbytes_reg, vbytes_shift, vbytes_next;
    logic [CW-1:0]      vwords_reg, vwords_next;
    logic               err_reg;

    logic               start_ok;
    logic               over_consume;
    logic               issue;
    logic [ADDR_W-1:0]  cur_addr;
    logic [CNT_W-1:0]   cur_issued;
    logic [CNT_W-1:0]   cur_expected;
    logic [CNT_W-1:0]   remaining;
    logic [TAG_W-1:0]   issue_tag;
    logic               land_valid;
    logic [TAG_W-1:0]   land_tag;
    logic [PCNT_W-1:0]  pipe_cnt;
    logic [BPW-1:0]     land_mask;
    int                 words_now;
    int                 eff_consume;
    int                 inflight;
    int                 occupancy;
    int                 tail_idx;

    imem_rd_pipe #(
        .RD_LAT (RD_LAT),
        .TAG_W  (TAG_W),
        .PCNT_W (PCNT_W)
    ) u_rd_pipe (
        .clk         (clk),
        .reset       (reset),
        .push        (~ceb_reg),
        .push_tag    (issue_tag_reg),
        .land_valid  (land_valid),
        .land_tag    (land_tag),
        .pending_cnt (pipe_cnt)
    );

    // Issue decision. A run being accepted this cycle uses the incoming
    // base/length directly so the first read goes out on the very next cycle.
    always_comb begin
        start_ok     = start && (state_reg != ST_FETCH);
        cur_addr     = start_ok ? base_addr : next_addr_reg;
        cur_issued   = start_ok ? '0 : issued_reg;
        cur_expected = start_ok ? expectedBytes : expected_reg;
        words_now    = start_ok ? 0 : int'(vwords_reg);
        inflight     = start_ok ? 0 : (int'(pipe_cnt) + int'(!ceb_reg));
        eff_consume  = 0;
        over_consume = 1'b0;
        if (!start_ok) begin
            if (int'(consume_words) > words_now) begin
                eff_consume  = words_now;
                over_consume = 1'b1;
            end else begin
                eff_consume  = int'(consume_words);
            end
        end
        occupancy = words_now - eff_consume + inflight;
        tail_idx  = words_now - eff_consume;
        remaining = cur_expected - cur_issued;
        issue_tag = (remaining >= CNT_W'(BPW)) ? TAG_W'(BPW) : remaining[TAG_W-1:0];
        issue     = (start_ok || (state_reg == ST_FETCH)) &&
                    (occupancy < WIN_WORDS) &&
                    (cur_issued < cur_expected);
    end

    // Run sequencing: a run is finished once every byte has been requested
    // and the only read still outstanding (if any) is landing right now.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = (expectedBytes == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if ((issued_reg >= expected_reg) && ((inflight - int'(land_valid)) == 0)) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // SRAM request registers and run counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            ceb_reg       <= 1'b1;
            addr_reg      <= '0;
            next_addr_reg <= '0;
            issued_reg    <= '0;
            expected_reg  <= '0;
            issue_tag_reg <= '0;
        end else begin
            ceb_reg       <= !issue;
            issue_tag_reg <= issue_tag;
            if (start_ok) begin
                expected_reg <= expectedBytes;
            end
            if (issue) begin
                addr_reg      <= cur_addr;
                next_addr_reg <= cur_addr + ADDR_W'(1);
                issued_reg    <= cur_issued + CNT_W'(issue_tag);
            end else if (start_ok) begin
                next_addr_reg <= base_addr;
                issued_reg    <= '0;
            end
        end
    end

    // Retire from the head first; a landing word then goes into the first
    // free slot behind whatever survived the shift.
    always_comb begin
        window_shift = start_ok ? '0 : (window_reg << (eff_consume * MEM_DW));
        vbytes_shift = start_ok ? '0 : (vbytes_reg << (eff_consume * BPW));
        land_mask    = ~({BPW{1'b1}} >> land_tag);
        vwords_next  = CW'(tail_idx + int'(land_valid));
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIN_WORDS; gi++) begin : g_slot
            logic slot_land;
            assign slot_land = land_valid && (tail_idx == gi);
            assign window_next[(WIN_WORDS-gi)*MEM_DW-1 -: MEM_DW] =
                slot_land ? imem_rdata : window_shift[(WIN_WORDS-gi)*MEM_DW-1 -: MEM_DW];
            assign vbytes_next[(WIN_WORDS-gi)*BPW-1 -: BPW] =
                slot_land ? land_mask : vbytes_shift[(WIN_WORDS-gi)*BPW-1 -: BPW];
        end
    endgenerate

    // Window contents, byte-valid map and word occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            window_reg <= '0;
            vbytes_reg <= '0;
            vwords_reg <= '0;
        end else begin
            window_reg <= window_next;
            vbytes_reg <= vbytes_next;
            vwords_reg <= vwords_next;
        end
    end

    // Sticky over-consume flag, cleared only by reset or a new run.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_reg <= 1'b0;
        end else if (start_ok) begin
            err_reg <= 1'b0;
        end else if (over_consume) begin
            err_reg <= 1'b1;
        end
    end

    assign imem_ceb                = ceb_reg;
    assign imem_web                = 1'b1;
    assign imem_addr               = addr_reg;
    assign instruction_word        = window_reg;
    assign instruction_valid_bytes = vbytes_reg;
    assign busy                    = (state_reg == ST_FETCH);
    assign done_reading_memory     = (state_reg == ST_DONE);
    assign consume_err             = err_reg;

endmodule

// File: tb/tb_imem_prefetch_buffer.sv
// Directed bench: one instance with single-cycle SRAM latency, one with
// three-cycle latency, each fed by a small behavioural SRAM model.
module tb_imem_prefetch_buffer;
    import imem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    // single-cycle latency instance
    logic         start1, ceb1, web1, busy1, done1, err1;
    logic [9:0]   base1, addr1;
    logic [16:0]  exp1;
    logic [2:0]   cons1;
    logic [31:0]  rdata1;
    logic [127:0] word1;
    logic [15:0]  vb1;
    // three-cycle latency instance
    logic         start3, ceb3, web3, busy3, done3, err3;
    logic [9:0]   base3, addr3;
    logic [16:0]  exp3;
    logic [2:0]   cons3;
    logic [31:0]  rdata3, s0_3, s1_3;
    logic [127:0] word3;
    logic [15:0]  vb3;

    int n_checks = 0;
    int n_fail   = 0;
    int iss1 = 0, iss3 = 0, peak3 = 0, snap;
    logic [2:0] hist3 = 3'b000;

    imem_prefetch_buffer #(.MEM_DW(32), .ADDR_W(10), .WIN_WORDS(4), .RD_LAT(1), .CNT_W(17)) u_dut (
        .clk(clk), .reset(reset), .imem_ceb(ceb1), .imem_web(web1), .imem_addr(addr1),
        .imem_rdata(rdata1), .start(start1), .base_addr(base1), .expectedBytes(exp1),
        .consume_words(cons1), .instruction_word(word1), .instruction_valid_bytes(vb1),
        .busy(busy1), .done_reading_memory(done1), .consume_err(err1));

    imem_prefetch_buffer #(.MEM_DW(32), .ADDR_W(10), .WIN_WORDS(4), .RD_LAT(3), .CNT_W(17)) u_dut3 (
        .clk(clk), .reset(reset), .imem_ceb(ceb3), .imem_web(web3), .imem_addr(addr3),
        .imem_rdata(rdata3), .start(start3), .base_addr(base3), .expectedBytes(exp3),
        .consume_words(cons3), .instruction_word(word3), .instruction_valid_bytes(vb3),
        .busy(busy3), .done_reading_memory(done3), .consume_err(err3));

    function automatic logic [31:0] dval(input logic [9:0] a);
        return 32'hC0DE_0000 | {22'd0, a};
    endfunction

    // SRAM models: garbage when not enabled so stray captures are visible.
    always @(posedge clk) rdata1 <= !ceb1 ? dval(addr1) : 32'hDEAD_BEEF;
    always @(posedge clk) begin
        s0_3   <= !ceb3 ? dval(addr3) : 32'hDEAD_BEEF;
        s1_3   <= s0_3;
        rdata3 <= s1_3;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, expv);
    endtask

    // Record SRAM activity of the current cycle, then move to the next sample point.
    task automatic tick();
        int o;
        if (!ceb1) iss1++;
        if (!ceb3) iss3++;
        hist3 = {hist3[1:0], !ceb3};
        o = int'(hist3[0]) + int'(hist3[1]) + int'(hist3[2]);
        if (o > peak3) peak3 = o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] seen [16];
        int nseen, first, last;

        reset = 1'b1;
        start1 = 0; base1 = '0; exp1 = '0; cons1 = '0;
        start3 = 0; base3 = '0; exp3 = '0; cons3 = '0;
        @(posedge clk); #1;
        tick(); tick();

        // Reset values
        check("rst_ceb",   128'(ceb1),  128'(1));
        check("rst_web",   128'(web1),  128'(1));
        check("rst_addr",  128'(addr1), 128'(0));
        check("rst_word",  word1,       128'(0));
        check("rst_vb",    128'(vb1),   128'(0));
        check("rst_busy",  128'(busy1), 128'(0));
        check("rst_done",  128'(done1), 128'(0));
        check("rst_err",   128'(err1),  128'(0));
        reset = 1'b0;
        tick();

        // 12-byte run from 0x010, no consume
        start1 = 1; base1 = 10'h010; exp1 = 17'd12;
        tick(); start1 = 0;
        check("r12_ceb1",  128'(ceb1),  128'(0));
        check("r12_addr1", 128'(addr1), 128'(10'h010));
        check("r12_busy",  128'(busy1), 128'(1));
        tick();
        check("r12_addr2", 128'(addr1), 128'(10'h011));
        tick();
        check("r12_addr3", 128'(addr1), 128'(10'h012));
        check("r12_ceb3",  128'(ceb1),  128'(0));
        check("r12_w0",    word1, {dval(10'h010), 96'd0});
        check("r12_vb_a",  128'(vb1),   128'(16'hF000));
        tick();
        check("r12_ceb4",  128'(ceb1),  128'(1));
        check("r12_done4", 128'(done1), 128'(0));
        tick();
        check("r12_vb",    128'(vb1),   128'(16'hFFF0));
        check("r12_done",  128'(done1), 128'(1));
        check("r12_busy5", 128'(busy1), 128'(0));
        check("r12_word",  word1, {dval(10'h010), dval(10'h011), dval(10'h012), 32'd0});

        // 10-byte run from 0x020: partial last word, no fourth read
        snap = iss1;
        start1 = 1; base1 = 10'h020; exp1 = 17'd10;
        tick(); start1 = 0;
        check("r10_done0", 128'(done1), 128'(0));
        check("r10_addr",  128'(addr1), 128'(10'h020));
        tick(); tick(); tick(); tick();
        check("r10_vb",    128'(vb1),   128'(16'hFFC0));
        check("r10_done",  128'(done1), 128'(1));
        check("r10_word",  word1, {dval(10'h020), dval(10'h021), dval(10'h022), 32'd0});
        tick(); tick(); tick();
        check("r10_reads", 128'(iss1 - snap), 128'(3));

        // Consume in DONE, then over-consume (3 with 2 valid)
        cons1 = 3'd1;
        tick(); cons1 = 3'd0;
        check("c1_word",   word1, {dval(10'h021), dval(10'h022), 64'd0});
        check("c1_vb",     128'(vb1),  128'(16'hFC00));
        check("c1_err",    128'(err1), 128'(0));
        cons1 = 3'd3;
        tick(); cons1 = 3'd0;
        check("oc_word",   word1,      128'(0));
        check("oc_vb",     128'(vb1),  128'(0));
        check("oc_err",    128'(err1), 128'(1));
        tick();
        check("oc_sticky", 128'(err1), 128'(1));

        // 40-byte run from 0x100, consume one word whenever the head is valid
        snap = iss1; nseen = 0; first = -1; last = -1;
        start1 = 1; base1 = 10'h100; exp1 = 17'd40;
        tick(); start1 = 0;
        check("st_clr_err", 128'(err1), 128'(0));
        for (int c = 1; c < 30; c++) begin
            if (!ceb1) begin
                if (first < 0) first = c;
                last = c;
            end
            if (vb1[15] && nseen < 16) begin
                seen[nseen] = word1[127:96];
                nseen++;
                cons1 = 3'd1;
            end else begin
                cons1 = 3'd0;
            end
            tick();
        end
        cons1 = 3'd0;
        check("s40_nseen", 128'(nseen),        128'(10));
        check("s40_reads", 128'(iss1 - snap),  128'(10));
        check("s40_span",  128'(last - first), 128'(9));
        for (int k = 0; k < 10; k++) begin
            check($sformatf("s40_w%0d", k), 128'(seen[k]), 128'(dval(10'(10'h100 + k))));
        end
        check("s40_done",  128'(done1), 128'(1));
        check("s40_vb",    128'(vb1),   128'(0));
        check("s40_err",   128'(err1),  128'(0));

        // RD_LAT=3, 32 bytes from 0x200, window limits issue to 4 words
        snap = iss3; peak3 = 0;
        start3 = 1; base3 = 10'h200; exp3 = 17'd32;
        tick(); start3 = 0;
        for (int c = 0; c < 20; c++) tick();
        check("l3_reads4", 128'(iss3 - snap), 128'(4));
        check("l3_peak",   128'(peak3),       128'(3));
        check("l3_vb",     128'(vb3),         128'(16'hFFFF));
        check("l3_word",   word3, {dval(10'h200), dval(10'h201), dval(10'h202), dval(10'h203)});
        check("l3_busy",   128'(busy3),       128'(1));
        cons3 = 3'd4;
        tick(); cons3 = 3'd0;
        for (int c = 0; c < 15; c++) tick();
        check("l3_reads8", 128'(iss3 - snap), 128'(8));
        check("l3_peak2",  128'(peak3),       128'(3));
        check("l3_word2",  word3, {dval(10'h204), dval(10'h205), dval(10'h206), dval(10'h207)});
        check("l3_done",   128'(done3),       128'(1));
        check("l3_err",    128'(err3),        128'(0));

        // Reset with two reads in flight on the single-cycle instance
        start1 = 1; base1 = 10'h300; exp1 = 17'd20;
        tick(); start1 = 0;
        tick();
        check("mr_ceb_pre", 128'(ceb1), 128'(0));
        reset = 1'b1;
        tick();
        check("mr_ceb",   128'(ceb1),  128'(1));
        check("mr_addr",  128'(addr1), 128'(0));
        check("mr_word",  word1,       128'(0));
        check("mr_vb",    128'(vb1),   128'(0));
        check("mr_busy",  128'(busy1), 128'(0));
        check("mr_done",  128'(done1), 128'(0));
        check("mr_err",   128'(err1),  128'(0));
        reset = 1'b0;
        tick(); tick(); tick();
        check("mr_late_w",  word1,      128'(0));
        check("mr_late_vb", 128'(vb1),  128'(0));
        check("mr_idle",    128'(ceb1), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
